// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register selects, PRId constant, exception codes
// and SR/Cause field bit positions.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [31:0] PRID_VALUE = 32'h2018_0007;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // EPC always holds a word-aligned address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_int_arb.sv
// CP0 exception arbiter: decides whether the pipeline must take an exception
// this cycle and which code lands in Cause.ExcCode. A pending, unmasked
// device interrupt outranks a simultaneous internal exception.
module cp0_int_arb
  import cp0_pkg::*;
(
  input  logic       i_exl,
  input  logic       i_ie,
  input  logic [5:0] i_im,
  input  logic [5:0] i_hwint,
  input  logic [4:0] i_exccode,
  output logic       o_int_req,
  output logic [4:0] o_exccode
);

  logic w_irq;
  logic w_exc;

  // Interrupt and internal-exception terms, both masked while EXL is set.
  always_comb begin
    w_irq     = i_ie & (|(i_hwint & i_im));
    w_exc     = (i_exccode != EXC_INT);
    o_int_req = ~i_exl & (w_irq | w_exc);
    o_exccode = w_irq ? EXC_INT : i_exccode;
  end

endmodule

// File: rtl/cp0.sv
// CP0 coprocessor: SR, Cause, EPC and PRId with mfc0/mtc0 access and
// exception/interrupt entry. Optional macro CP0_BD_EN enables delay-slot
// handling (Cause.BD and EPC = PC-4 for a faulting delay-slot instruction).
module cp0
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  input  logic        BD,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic        w_bd;

  logic        w_int_req;
  logic [4:0]  w_exc_sel;
  logic [31:0] w_epc_next;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  cp0_int_arb u_int_arb (
    .i_exl     (r_exl),
    .i_ie      (r_ie),
    .i_im      (r_im),
    .i_hwint   (HWInt),
    .i_exccode (ExcCode),
    .o_int_req (w_int_req),
    .o_exccode (w_exc_sel)
  );

`ifdef CP0_BD_EN
  logic r_bd;

  // A faulting delay-slot instruction restarts at its branch.
  always_comb begin
    w_epc_next = word_align(BD ? (PC - 32'd4) : PC);
    w_bd       = r_bd;
  end

  // Cause.BD follows the committing instruction on every exception entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_bd <= 1'b0;
    else if (w_int_req) r_bd <= BD;
  end
`else
  logic w_unused_bd;

  // Without delay-slot support BD is ignored and Cause.BD reads 0.
  always_comb begin
    w_epc_next  = word_align(PC);
    w_bd        = 1'b0;
    w_unused_bd = BD;
  end
`endif

  // SR/Cause/EPC update: entry beats mtc0 and eret; IP samples HWInt always.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= HWInt;
      if (w_int_req) begin
        r_exl     <= 1'b1;
        r_epc     <= w_epc_next;
        r_exccode <= w_exc_sel;
      end else begin
        if (WE && (A2 == REG_SR)) begin
          r_im  <= DIn[SR_IM_HI:SR_IM_LO];
          r_exl <= DIn[SR_EXL];
          r_ie  <= DIn[SR_IE];
        end else if (WE && (A2 == REG_EPC)) begin
          r_epc <= word_align(DIn);
        end
        if (EXLClr) r_exl <= 1'b0;
      end
    end
  end

  // Register views assembled from their fields; unlisted bits read 0.
  always_comb begin
    w_sr                                = '0;
    w_sr[SR_IM_HI:SR_IM_LO]             = r_im;
    w_sr[SR_EXL]                        = r_exl;
    w_sr[SR_IE]                         = r_ie;
    w_cause                             = '0;
    w_cause[CAUSE_BD]                   = w_bd;
    w_cause[CAUSE_IP_HI:CAUSE_IP_LO]    = r_ip;
    w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO]  = r_exccode;
  end

  // mfc0 read mux and direct outputs (no same-cycle forwarding).
  always_comb begin
    IntReq = w_int_req;
    EPC    = r_epc;
    DOut   = '0;
    case (A1)
      REG_SR:    DOut = w_sr;
      REG_CAUSE: DOut = w_cause;
      REG_EPC:   DOut = r_epc;
      REG_PRID:  DOut = PRID_VALUE;
      default:   DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Directed testbench for cp0 with hand-computed expected values.
// Expectations for the delay-slot case follow the CP0_BD_EN macro.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        BD;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  int n_checks = 0;
  int n_errors = 0;

  cp0 dut (
    .clk     (clk),
    .reset   (reset),
    .A1      (A1),
    .A2      (A2),
    .DIn     (DIn),
    .WE      (WE),
    .PC      (PC),
    .ExcCode (ExcCode),
    .HWInt   (HWInt),
    .EXLClr  (EXLClr),
    .BD      (BD),
    .IntReq  (IntReq),
    .EPC     (EPC),
    .DOut    (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] sel, input logic [31:0] exp);
    A1 = sel;
    #1;
    check(tag, DOut, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = '0; WE = 1'b0; PC = '0;
    ExcCode = 5'd0; HWInt = 6'd0; EXLClr = 1'b0; BD = 1'b0;
    step();
    step();

    // Reset state
    check_reg("rst_sr", 5'd12, 32'h0);
    check_reg("rst_cause", 5'd13, 32'h0);
    check_reg("rst_epcreg", 5'd14, 32'h0);
    check_reg("rst_prid", 5'd15, 32'h2018_0007);
    check_reg("rst_unmapped", 5'd3, 32'h0);
    check("rst_intreq", {31'd0, IntReq}, 32'd0);
    check("rst_epc", EPC, 32'h0);
    reset = 1'b0;
    step();

    // mtc0 SR = 0x401 (IM0, IE)
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    step();
    WE = 1'b0;
    check_reg("mtc0_sr", 5'd12, 32'h0000_0401);
    check("no_irq_idle", {31'd0, IntReq}, 32'd0);

    // Timer interrupt entry
    PC = 32'h0000_3008; HWInt = 6'b000001;
    #1;
    check("irq_req", {31'd0, IntReq}, 32'd1);
    step();
    check("irq_epc", EPC, 32'h0000_3008);
    check_reg("irq_cause", 5'd13, 32'h0000_0400);
    check_reg("irq_sr", 5'd12, 32'h0000_0403);
    check("irq_masked_exl", {31'd0, IntReq}, 32'd0);

    // eret: EXL clears, pending interrupt re-raises
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    check_reg("eret_sr", 5'd12, 32'h0000_0401);
    check("eret_intreq", {31'd0, IntReq}, 32'd1);
    HWInt = 6'd0;
    #1;
    check("irq_drop", {31'd0, IntReq}, 32'd0);

    // Internal exception (RI) with SR = 0
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0;
    step();
    WE = 1'b0;
    ExcCode = 5'd10; PC = 32'h0000_3010;
    #1;
    check("exc_req", {31'd0, IntReq}, 32'd1);
    step();
    ExcCode = 5'd0;
    check_reg("exc_cause", 5'd13, 32'h0000_0028);
    check("exc_epc", EPC, 32'h0000_3010);
    check_reg("exc_sr", 5'd12, 32'h0000_0002);

    // Writes to Cause and PRId are ignored
    WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    step();
    A2 = 5'd15;
    step();
    WE = 1'b0;
    check_reg("cause_wr_ign", 5'd13, 32'h0000_0028);
    check_reg("prid_wr_ign", 5'd15, 32'h2018_0007);

    // Entry collides with mtc0 EPC: entry wins
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_4000; ExcCode = 5'd4; PC = 32'h0000_3020;
    step();
    WE = 1'b0; ExcCode = 5'd0;
    check("coll_epc", EPC, 32'h0000_3020);
    check_reg("coll_cause", 5'd13, 32'h0000_0010);

    // Plain mtc0 EPC, low bits forced to 0
    WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_4003;
    step();
    WE = 1'b0;
    check("mtc0_epc", EPC, 32'h0000_4000);
    check_reg("mtc0_epc_rd", 5'd14, 32'h0000_4000);

    // Interrupt beats internal exception; entry beats eret
    EXLClr = 1'b1; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    step();
    WE = 1'b0;
    check_reg("sr_wr_eret", 5'd12, 32'h0000_0401);
    HWInt = 6'b000001; ExcCode = 5'd12; PC = 32'h0000_3030;
    step();
    check_reg("prio_cause", 5'd13, 32'h0000_0400);
    check("prio_epc", EPC, 32'h0000_3030);
    check_reg("prio_sr", 5'd12, 32'h0000_0403);

    // Delay-slot exception (Ov)
    HWInt = 6'd0; ExcCode = 5'd0; EXLClr = 1'b1; WE = 1'b1; A2 = 5'd12; DIn = 32'h0;
    step();
    EXLClr = 1'b0; WE = 1'b0;
    check_reg("bd_pre_sr", 5'd12, 32'h0);
    ExcCode = 5'd12; BD = 1'b1; PC = 32'h0000_3024;
    step();
    ExcCode = 5'd0; BD = 1'b0;
`ifdef CP0_BD_EN
    check("bd_epc", EPC, 32'h0000_3020);
    check_reg("bd_cause", 5'd13, 32'h8000_0030);
`else
    check("bd_epc", EPC, 32'h0000_3024);
    check_reg("bd_cause", 5'd13, 32'h0000_0030);
`endif

    // Mid-cycle asynchronous reset, no clock edge needed
    HWInt = 6'h3F;
    #2;
    reset = 1'b1;
    #1;
    check("arst_intreq", {31'd0, IntReq}, 32'd0);
    check("arst_epc", EPC, 32'h0);
    A1 = 5'd12;
    #1;
    check("arst_sr", DOut, 32'h0);
    A1 = 5'd13;
    #1;
    check("arst_cause", DOut, 32'h0);
    A1 = 5'd7;
    #1;
    check("arst_unmapped", DOut, 32'h0);
    step();
    reset = 1'b0;

    // IP samples HWInt regardless of EXL/IE
    step();
    check_reg("ip_sample", 5'd13, 32'h0000_FC00);
    check("ip_no_req", {31'd0, IntReq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
